div_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the CPU's integer divide. It accepts a dividend/divisor pair on a start pulse and runs a shift-subtract restoring division one quotient bit per clock, using a single shared 32-bit subtractor. It handles sign pre- and post-correction and presents quotient (LO) and remainder (HI) for writeback to the HI/LO registers. It sits between the control unit's DIV micro-step and the HI/LO register write path.

---
 rtl/div_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_div_seq_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// ============================================================================
// Module   : div_seq_ctrl
// Purpose  : Multi-cycle integer divide sequencer. It runs a restoring
//            shift-subtract division that produces one quotient bit per clock
//            through a single shared 32-bit subtractor. Operands are captured
//            on an accepted start pulse. Results are presented as
//            {remainder, quotient} for the HI/LO writeback path.
// Ports    : clock  - system clock, rising edge
//            clear  - asynchronous active-high reset
//            start  - request pulse, sampled only while idle
//            a      - dividend [31:0]
//            m      - divisor  [31:0]
//            busy   - high from the accepting edge until the done cycle ends
//            done   - one-cycle pulse; q/dbz valid
//            dbz    - divide-by-zero flag, held until the next accept
//            q      - {remainder, quotient}; HI = q[63:32], LO = q[31:0]
// Config   : DIV_SIGNED_EN - when defined, operands are two's-complement.
//            Magnitudes are divided and signs are restored in the fix-up
//            cycle. When undefined, operation is unsigned only.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq_ctrl (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] m,
    output logic        busy,
    output logic        done,
    output logic        dbz,
    output logic [63:0] q
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [63:0] r_acc;     // {A, Q}
    logic [31:0] r_m;
    logic [5:0]  r_cnt;
    logic        r_sq;
    logic        r_sr;

    logic [31:0] w_cap_a;
    logic [31:0] w_cap_m;
    logic        w_cap_sq;
    logic        w_cap_sr;
    logic [63:0] w_shift;
    logic [32:0] w_diff;
    logic        w_fit;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    // Operand capture: magnitudes and sign flags in signed mode, raw values otherwise.
    // The sign flags stay zero in unsigned mode, so the fix-up negation below
    // reduces to a pass-through while still occupying its cycle.
`ifdef DIV_SIGNED_EN
    assign w_cap_a  = a[31] ? (32'd0 - a) : a;
    assign w_cap_m  = m[31] ? (32'd0 - m) : m;
    assign w_cap_sq = a[31] ^ m[31];
    assign w_cap_sr = a[31];
`else
    assign w_cap_a  = a;
    assign w_cap_m  = m;
    assign w_cap_sq = 1'b0;
    assign w_cap_sr = 1'b0;
`endif

    // The bit shifted out of A is kept as the 33rd subtractor bit. With a
    // divisor at or above 2^31, the shifted partial remainder can reach 33
    // bits. Whenever that bit is set, the subtraction always fits.
    assign w_shift = {r_acc[62:0], 1'b0};
    assign w_diff  = {r_acc[63], w_shift[63:32]} - {1'b0, r_m};
    assign w_fit   = ~w_diff[32];

    assign w_quo = r_sq ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
    assign w_rem = r_sr ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    // ---------------------------------------------------------------- FSM
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (m == 32'd0) ? S_DONE : S_ITER;
            S_ITER:  if (r_cnt == 6'd31) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // busy/done are registered from the next state so that they track the
    // state register exactly without a decode stage after it.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_next;
            busy    <= (w_next != S_IDLE);
            done    <= (w_next == S_DONE);
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_acc <= 64'd0;
            r_m   <= 32'd0;
            r_cnt <= 6'd0;
            r_sq  <= 1'b0;
            r_sr  <= 1'b0;
            dbz   <= 1'b0;
            q     <= 64'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (m == 32'd0) begin
                            dbz <= 1'b1;
                            q   <= {a, 32'hFFFF_FFFF};
                        end else begin
                            dbz   <= 1'b0;
                            r_acc <= {32'd0, w_cap_a};
                            r_m   <= w_cap_m;
                            r_sq  <= w_cap_sq;
                            r_sr  <= w_cap_sr;
                            r_cnt <= 6'd0;
                        end
                    end
                end
                S_ITER: begin
                    r_acc <= w_fit ? {w_diff[31:0], w_shift[31:1], 1'b1} : w_shift;
                    r_cnt <= r_cnt + 6'd1;
                end
                S_FIX: begin
                    q <= {w_rem, w_quo};
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_seq_ctrl.sv
// ============================================================================
// Module   : tb_div_seq_ctrl
// Purpose  : Self-checking bench for div_seq_ctrl. A plain-arithmetic
//            reference model (signed or unsigned, following DIV_SIGNED_EN)
//            checks directed corner cases and randomized operand pairs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq_ctrl;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] a;
    logic [31:0] m;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [63:0] q;

    int n_checks;
    int n_fail;

    div_seq_ctrl dut (
        .clock (clock),
        .clear (clear),
        .start (start),
        .a     (a),
        .m     (m),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .q     (q)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {dbz, remainder, quotient}.
    function automatic logic [64:0] ref_div(input logic [31:0] x, input logic [31:0] y);
`ifdef DIV_SIGNED_EN
        longint sx;
        longint sy;
        longint qq;
        longint rr;
`else
        logic [31:0] qu;
        logic [31:0] ru;
`endif
        if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
`ifdef DIV_SIGNED_EN
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        qq = sx / sy;
        rr = sx % sy;
        return {1'b0, rr[31:0], qq[31:0]};
`else
        qu = x / y;
        ru = x % y;
        return {1'b0, ru, qu};
`endif
    endfunction

    // Issue one operation from a falling edge with the DUT idle. Then check
    // latency, busy coverage, result, flag and single-cycle done. If
    // inject_at > 0, a stray start (9/3) is pulsed at that cycle of the run.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tm, input int inject_at);
        logic [64:0] exp;
        int          lat;
        int          extra;
        logic        busy_ok;
        exp   = ref_div(ta, tm);
        a     = ta;
        m     = tm;
        start = 1'b1;
        @(negedge clock);
        start   = 1'b0;
        a       = $urandom;
        m       = $urandom;
        lat     = 1;
        busy_ok = 1'b1;
        while (!done && lat < 60) begin
            if (!busy) busy_ok = 1'b0;
            if (lat == inject_at) begin
                start = 1'b1;
                a     = 32'd9;
                m     = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        check_eq("latency", 64'(lat), exp[64] ? 64'd1 : 64'd34);
        check_eq("busy_span", {63'd0, busy_ok & busy}, 64'd1);
        check_eq("q", q, exp[63:0]);
        check_eq("dbz", {63'd0, dbz}, {63'd0, exp[64]});
        @(negedge clock);
        check_eq("done_one_cycle", {62'd0, busy, done}, 64'd0);
        if (inject_at > 0) begin
            extra = 0;
            repeat (40) begin
                @(negedge clock);
                if (done || busy) extra++;
            end
            check_eq("no_second_op", 64'(extra), 64'd0);
        end
    endtask

    initial begin
        int          seen;
        logic [31:0] ra;
        logic [31:0] rm;
        n_checks = 0;
        n_fail   = 0;
        clock    = 1'b0;
        clear    = 1'b1;
        start    = 1'b0;
        a        = 32'd0;
        m        = 32'd0;
        repeat (2) @(negedge clock);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_dbz",  {63'd0, dbz},  64'd0);
        check_eq("rst_q",    q,             64'd0);
        clear = 1'b0;
        @(negedge clock);

        run_op(32'd100, 32'd7, 0);
        check_eq("basic_q", q, {32'd2, 32'd14});
`ifdef DIV_SIGNED_EN
        run_op(32'hFFFF_FF9C, 32'd7, 0);
        check_eq("neg_div_q", q, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        run_op(32'd100, 32'hFFFF_FFF9, 0);
        check_eq("neg_dsr_q", q, {32'd2, 32'hFFFF_FFF2});
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
        check_eq("ovf_q", q, {32'd0, 32'h8000_0000});
`endif
        run_op(32'h1234_5678, 32'd0, 0);
        check_eq("dbz_q", q, {32'h1234_5678, 32'hFFFF_FFFF});
        repeat (3) @(negedge clock);
        check_eq("dbz_held", {63'd0, dbz}, 64'd1);
        run_op(32'd10, 32'd3, 0);
        check_eq("after_dbz_q", q, {32'd1, 32'd3});

        // Stray start during ITER must be ignored.
        run_op(32'd1000, 32'd7, 11);

        // Clear in the middle of ITER abandons the operation.
        a     = 32'd5000;
        m     = 32'd3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (15) @(negedge clock);
        clear = 1'b1;
        #1;
        check_eq("clr_busy", {63'd0, busy}, 64'd0);
        check_eq("clr_done", {63'd0, done}, 64'd0);
        check_eq("clr_q",    q,             64'd0);
        @(negedge clock);
        clear = 1'b0;
        seen  = 0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) seen++;
        end
        check_eq("clr_no_done", 64'(seen), 64'd0);
        run_op(32'd12345, 32'd67, 0);

        // Randomized operand pairs.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 4))
                0:       rm = 32'd0;
                1:       rm = $urandom_range(1, 15);
                2:       rm = ~($urandom_range(0, 15));
                3:       rm = 32'h8000_0000 | $urandom_range(0, 3);
                default: rm = $urandom;
            endcase
            run_op(ra, rm, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
